// File: rtl/alu16.sv
// alu16: registered 16-bit ADD/SUB/AND/OR unit with carry, zero and overflow flags
module alu16 #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] o,
    output logic             c_out,
    output logic             zero,
    output logic             ovf,
    output logic             out_valid
);
    logic [WIDTH-1:0] b_x;
    logic [WIDTH-1:0] res;
    logic [WIDTH:0]   sum;
    logic             cy;
    logic             v;
    always_comb begin
        b_x = op[0] ? ~b : b;
        sum = {1'b0, a} + {1'b0, b_x} + {{WIDTH{1'b0}}, op[0]};
        res = op[1] ? (op[0] ? (a | b) : (a & b)) : sum[WIDTH-1:0];
        cy  = !op[1] && sum[WIDTH];
        v   = !op[1] && (a[WIDTH-1] == b_x[WIDTH-1]) && (res[WIDTH-1] != a[WIDTH-1]);
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            o         <= '0;
            c_out     <= 1'b0;
            zero      <= 1'b0;
            ovf       <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                o     <= res;
                c_out <= cy;
                zero  <= (res == '0);
                ovf   <= v;
            end
        end
    end
endmodule

// File: tb/tb_alu16.sv
// tb_alu16: directed vector table, hold/reset sequences and random checks against an arithmetic model
module tb_alu16;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [1:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] o;
    logic        c_out;
    logic        zero;
    logic        ovf;
    logic        out_valid;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [1:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] o;
        logic        c;
        logic        z;
        logic        v;
    } vec_t;

    vec_t vecs[16];

    alu16 dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .op(op), .a(a), .b(b),
        .o(o), .c_out(c_out), .zero(zero), .ovf(ovf), .out_valid(out_valid)
    );

    always #5 clk = ~clk;

    function automatic logic [18:0] model(input logic [1:0] f, input logic [15:0] x, input logic [15:0] y);
        int ux = int'(x);
        int uy = int'(y);
        int sx = int'($signed(x));
        int sy = int'($signed(y));
        int r = 0;
        int sr = 0;
        logic c = 1'b0;
        logic v = 1'b0;
        logic [15:0] res;
        case (f)
            2'd0: begin r = ux + uy; sr = sx + sy; c = (r > 65535); end
            2'd1: begin r = ux - uy; sr = sx - sy; c = (ux >= uy); end
            2'd2: r = int'(x & y);
            default: r = int'(x | y);
        endcase
        if (f[1] == 1'b0) v = (sr > 32767) || (sr < -32768);
        res = r[15:0];
        return {res, c, (res == 16'h0000), v};
    endfunction

    task automatic check(input string name, input logic [19:0] exp);
        logic [19:0] got;
        got = {o, c_out, zero, ovf, out_valid};
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got o/c/z/v/vld=%h/%b/%b/%b/%b required %h/%b/%b/%b/%b",
                     name, got[19:4], got[3], got[2], got[1], got[0],
                     exp[19:4], exp[3], exp[2], exp[1], exp[0]);
        end
    endtask

    task automatic step(input logic r, input logic iv, input logic [1:0] f, input logic [15:0] x, input logic [15:0] y);
        rst_n = r; in_valid = iv; op = f; a = x; b = y;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [15:0] m_o;
        logic        m_c, m_z, m_v;
        logic [18:0] m;
        vecs[0]  = '{2'd0, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0};
        vecs[1]  = '{2'd0, 16'haa55, 16'h55aa, 16'hffff, 1'b0, 1'b0, 1'b0};
        vecs[2]  = '{2'd0, 16'hffff, 16'h0001, 16'h0000, 1'b1, 1'b1, 1'b0};
        vecs[3]  = '{2'd0, 16'h0001, 16'h7fff, 16'h8000, 1'b0, 1'b0, 1'b1};
        vecs[4]  = '{2'd1, 16'h0000, 16'h0000, 16'h0000, 1'b1, 1'b1, 1'b0};
        vecs[5]  = '{2'd1, 16'haa55, 16'h55aa, 16'h54ab, 1'b1, 1'b0, 1'b1};
        vecs[6]  = '{2'd1, 16'hffff, 16'h0001, 16'hfffe, 1'b1, 1'b0, 1'b0};
        vecs[7]  = '{2'd1, 16'h0001, 16'h7fff, 16'h8002, 1'b0, 1'b0, 1'b0};
        vecs[8]  = '{2'd2, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0};
        vecs[9]  = '{2'd2, 16'haa55, 16'h55aa, 16'h0000, 1'b0, 1'b1, 1'b0};
        vecs[10] = '{2'd2, 16'hffff, 16'h0001, 16'h0001, 1'b0, 1'b0, 1'b0};
        vecs[11] = '{2'd2, 16'h0001, 16'h7fff, 16'h0001, 1'b0, 1'b0, 1'b0};
        vecs[12] = '{2'd3, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0};
        vecs[13] = '{2'd3, 16'haa55, 16'h55aa, 16'hffff, 1'b0, 1'b0, 1'b0};
        vecs[14] = '{2'd3, 16'hffff, 16'h0001, 16'hffff, 1'b0, 1'b0, 1'b0};
        vecs[15] = '{2'd3, 16'h0001, 16'h7fff, 16'h7fff, 1'b0, 1'b0, 1'b0};

        for (int i = 0; i < 2; i++) begin
            step(1'b0, 1'b1, 2'd0, 16'hffff, 16'h0001);
            check("reset", 20'h0);
        end

        for (int i = 0; i < 16; i++) begin
            step(1'b1, 1'b1, vecs[i].op, vecs[i].a, vecs[i].b);
            check($sformatf("vec%0d", i), {vecs[i].o, vecs[i].c, vecs[i].z, vecs[i].v, 1'b1});
        end

        step(1'b1, 1'b1, 2'd0, 16'hffff, 16'h0001);
        check("hold_issue", {16'h0000, 1'b1, 1'b1, 1'b0, 1'b1});
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b0, 2'(i + 1), 16'(i * 16'h1234 + 5), 16'(16'h0f0f ^ i));
            check($sformatf("hold%0d", i), {16'h0000, 1'b1, 1'b1, 1'b0, 1'b0});
        end

        step(1'b1, 1'b1, 2'd1, 16'h0003, 16'h0005);
        check("mid_pre", {16'hfffe, 1'b0, 1'b0, 1'b0, 1'b1});
        step(1'b0, 1'b1, 2'd0, 16'h7fff, 16'h7fff);
        check("mid_rst", 20'h0);
        step(1'b1, 1'b1, 2'd1, 16'h0005, 16'h0003);
        check("mid_post", {16'h0002, 1'b1, 1'b0, 1'b0, 1'b1});

        m_o = o; m_c = c_out; m_z = zero; m_v = ovf;
        for (int i = 0; i < 300; i++) begin
            logic        iv;
            logic [1:0]  f;
            logic [15:0] x, y;
            iv = ($urandom_range(0, 3) != 0);
            f  = 2'($urandom_range(0, 3));
            x  = 16'($urandom);
            y  = (i % 10 == 0) ? x : 16'($urandom);
            step(1'b1, iv, f, x, y);
            if (iv) begin
                m = model(f, x, y);
                {m_o, m_c, m_z, m_v} = m;
            end
            check($sformatf("rand%0d", i), {m_o, m_c, m_z, m_v, iv});
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
